// File: rtl/mod_counter.sv
// Loadable up/down counter with runtime limit, wrap/saturate, one-shot halt and a registered terminal pulse.
// Optional MOD_COUNTER_SNAP_EN adds a snap input that captures the pre-update count into snap_val.
module mod_counter #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic             oneshot,
`ifdef MOD_COUNTER_SNAP_EN
    input  logic             snap,
    output logic [WIDTH-1:0] snap_val,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             co,
    output logic             tc,
    output logic             halted
);

    typedef enum logic {
        COUNT = 1'b0,
        HALT  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             halted_q, halted_d;
    logic             term;
    logic             counting;

    // Up-count treats anything at or above limit as terminal, so a load past limit never runs through the top.
    assign term     = dir ? (cnt_q >= limit) : (cnt_q == '0);
    assign counting = (state_q == COUNT);
    assign co       = en & term & counting & ~clr & ~ld;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        tc_d    = co;
        if (clr) begin
            cnt_d   = RST_VAL;
            state_d = COUNT;
        end else if (ld) begin
            cnt_d   = ld_val;
            state_d = COUNT;
        end else if (en && counting) begin
            if (term) begin
                if (oneshot) begin
                    state_d = HALT;
                end else if (dir) begin
                    cnt_d = sat ? cnt_q : '0;
                end else begin
                    cnt_d = sat ? '0 : limit;
                end
            end else begin
                cnt_d = dir ? (cnt_q + ONE) : (cnt_q - ONE);
            end
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COUNT;
            cnt_q    <= RST_VAL;
            tc_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            halted_q <= halted_d;
        end
    end

    assign cnt    = cnt_q;
    assign tc     = tc_q;
    assign halted = halted_q;

`ifdef MOD_COUNTER_SNAP_EN
    logic [WIDTH-1:0] snap_val_q, snap_val_d;

    // Only rst clears the snapshot; clr and ld deliberately leave it alone.
    always_comb begin
        snap_val_d = snap ? cnt_q : snap_val_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_val_q <= '0;
        end else begin
            snap_val_q <= snap_val_d;
        end
    end

    assign snap_val = snap_val_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter (WIDTH=6, RST_VAL=0): wrap, saturate, reload, one-shot, priority, async reset.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst, clr, en, ld, dir, sat, oneshot;
    logic [5:0] ld_val, limit;
    logic [5:0] cnt;
    logic       co, tc, halted;
`ifdef MOD_COUNTER_SNAP_EN
    logic       snap;
    logic [5:0] snap_val;
`endif

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [5:0] exp_cnt;
    logic       prev_term;

    mod_counter #(.WIDTH(6), .RST_VAL(6'd0)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .ld      (ld),
        .ld_val  (ld_val),
        .dir     (dir),
        .limit   (limit),
        .sat     (sat),
        .oneshot (oneshot),
`ifdef MOD_COUNTER_SNAP_EN
        .snap    (snap),
        .snap_val(snap_val),
`endif
        .cnt     (cnt),
        .co      (co),
        .tc      (tc),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; ld = 1'b0; dir = 1'b1; sat = 1'b0;
        oneshot = 1'b0; ld_val = 6'd0; limit = 6'd5;
`ifdef MOD_COUNTER_SNAP_EN
        snap = 1'b0;
`endif
        step();
        chk("rst_cnt", cnt, 0);
        chk("rst_tc", tc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_co", co, 0);
        rst = 1'b0;

        // Up wrap, limit 5: 0,1,2,3,4,5,0,1
        en = 1'b1; dir = 1'b1; sat = 1'b0; limit = 6'd5;
        prev_term = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_cnt = (i < 6) ? 6'(i) : 6'(i - 6);
            #1;
            chk("upw_cnt", cnt, exp_cnt);
            chk("upw_co", co, exp_cnt == 6'd5);
            chk("upw_tc", tc, prev_term);
            prev_term = (exp_cnt == 6'd5);
            step();
        end

        // Down saturate from a load of 3: 3,2,1,0,0,0
        en = 1'b0; ld = 1'b1; ld_val = 6'd3;
        step();
        ld = 1'b0; dir = 1'b0; sat = 1'b1; en = 1'b1;
        prev_term = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_cnt = (i < 3) ? 6'(3 - i) : 6'd0;
            #1;
            chk("dsat_cnt", cnt, exp_cnt);
            chk("dsat_co", co, exp_cnt == 6'd0);
            chk("dsat_tc", tc, prev_term);
            prev_term = (exp_cnt == 6'd0);
            step();
        end

        // Down wrap reloads limit: 1,0,10,9
        en = 1'b0; ld = 1'b1; ld_val = 6'd1; limit = 6'd10;
        step();
        ld = 1'b0; dir = 1'b0; sat = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_cnt = (i == 0) ? 6'd1 : (i == 1) ? 6'd0 : (i == 2) ? 6'd10 : 6'd9;
            #1;
            chk("dwr_cnt", cnt, exp_cnt);
            chk("dwr_co", co, exp_cnt == 6'd0);
            step();
        end

        // One-shot up to limit 2: 0,1,2,2,2 with halt after the terminal step
        en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; limit = 6'd2; oneshot = 1'b1; dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_cnt = (i < 2) ? 6'(i) : 6'd2;
            #1;
            chk("os_cnt", cnt, exp_cnt);
            chk("os_halted", halted, i >= 3);
            chk("os_co", co, i == 2);
            chk("os_tc", tc, i == 3);
            step();
        end
        ld = 1'b1; ld_val = 6'd7;
        step();
        chk("os_ld_cnt", cnt, 7);
        chk("os_ld_halted", halted, 0);
        ld = 1'b0; en = 1'b0; oneshot = 1'b0;

        // Priority: clr beats ld beats counting
        ld = 1'b1; ld_val = 6'd4;
        step();
        chk("pri_pre_cnt", cnt, 4);
        clr = 1'b1; ld = 1'b1; ld_val = 6'd9; en = 1'b1; limit = 6'd20; dir = 1'b1;
        #1;
        chk("pri_clr_co", co, 0);
        step();
        chk("pri_clr_cnt", cnt, 0);
        clr = 1'b0;
        #1;
        chk("pri_ld_co", co, 0);
        step();
        chk("pri_ld_cnt", cnt, 9);
        chk("pri_ld_tc", tc, 0);

        // Async reset while halted with a pending tc pulse
        en = 1'b0; ld = 1'b1; ld_val = 6'd3; limit = 6'd3; oneshot = 1'b1;
        step();
        ld = 1'b0; en = 1'b1;
        step();
        chk("ar_pre_cnt", cnt, 3);
        chk("ar_pre_halted", halted, 1);
        chk("ar_pre_tc", tc, 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_cnt", cnt, 0);
        chk("ar_halted", halted, 0);
        chk("ar_tc", tc, 0);
        rst = 1'b0; en = 1'b0; oneshot = 1'b0;
        step();
        chk("ar_post_cnt", cnt, 0);
        chk("ar_post_tc", tc, 0);

`ifdef MOD_COUNTER_SNAP_EN
        chk("snap_rst", snap_val, 0);
        ld = 1'b1; ld_val = 6'd4;
        step();
        ld = 1'b0; snap = 1'b1;
        step();
        chk("snap_cap", snap_val, 4);
        snap = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("snap_clr_cnt", cnt, 0);
        chk("snap_hold", snap_val, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised, loadable up/down counter with programmable terminal value, wrap or saturate mode, and a one-shot halt mode.
- Next-generation replacement for the fixed 6-bit up-counter with carry-out, used as a loop/index counter in datapath controllers.
- Adds a direction input, a runtime limit, sync clear, a registered terminal pulse and a halt state machine.

Parameters:
- WIDTH, 6, counter width in bits (>=2).
- RST_VAL, 0, value loaded into cnt on rst and clr (WIDTH bits).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous clear to RST_VAL, returns to COUNT state.
- en  input  1  count enable.
- ld  input  1  synchronous load of ld_val, returns to COUNT state.
- ld_val  input  WIDTH  load value.
- dir  input  1  1 = count up, 0 = count down.
- limit  input  WIDTH  terminal value for up-count, reload value for down-count.
- sat  input  1  1 = saturate at terminal, 0 = wrap.
- oneshot  input  1  1 = halt after the first terminal step.
- cnt  output  WIDTH  current count (registered).
- co  output  1  combinational carry-out / terminal strobe.
- tc  output  1  registered one-cycle terminal pulse.
- halted  output  1  1 while in HALT state.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset: cnt=RST_VAL, tc=0, state=COUNT, halted=0. co is 0 whenever en=0.
- Priority per edge: rst > clr > ld > counting. clr and ld act in both states and force state=COUNT and tc=0 on that edge.
- Terminal condition: term = dir ? (cnt >= limit) : (cnt == 0).
- Counting step, when en=1, state=COUNT, no clr/ld:
  - Non-terminal: cnt +1 (up) or -1 (down).
  - Terminal, up: next cnt = sat ? cnt (hold) : 0.
  - Terminal, down: next cnt = sat ? 0 (hold) : limit.
  - oneshot=1 overrides both: cnt holds and state -> HALT.
- A loaded value above limit in up mode is terminal immediately; there is no counting through 2^WIDTH-1.
- co = en & term & (state==COUNT) & ~clr & ~ld. Combinational, same cycle as the terminal step.
- tc: registered copy of co. High for exactly one cycle after each terminal step. In saturate mode it repeats every enabled cycle while at terminal.
- State machine: COUNT -> HALT on a terminal step with oneshot=1. HALT -> COUNT only on clr or ld. In HALT: en ignored, cnt frozen, co=0, halted=1.
- Changes to limit, dir, sat and oneshot take effect on the next evaluated edge; no internal latching.
- All arithmetic is modulo 2^WIDTH; no intermediate wider than WIDTH+1.
- rst mid-count or in HALT: immediate return to reset values, no tc pulse.

Optional Feature:
- Macro: MOD_COUNTER_SNAP_EN.
- Defined: adds input snap (1 bit) and output snap_val (WIDTH bits, reset 0).
  - On an edge with snap=1, snap_val <= cnt (pre-update value).
  - Valid in both states; unaffected by clr/ld; only rst clears it.
- Undefined: neither port exists; no extra registers.

Test Plan (WIDTH=6):
- Up wrap: rst, limit=5, dir=1, sat=0, en=1 for 8 cycles -> cnt 0,1,2,3,4,5,0,1; co=1 in the cycle cnt=5; tc=1 the following cycle only.
- Down saturate: ld_val=3, ld=1 one cycle, then dir=0, sat=1, en=1 -> cnt 3,2,1,0,0,0; co=1 while cnt=0 and en=1; tc repeats each cycle.
- Down wrap reload: limit=10, cnt=1, dir=0, sat=0 -> cnt 1,0,10,9.
- One-shot: limit=2, oneshot=1, up from 0 -> cnt 0,1,2,2,2; halted=1 from cycle 4; co=0 while halted; ld with ld_val=7 -> cnt=7, halted=0.
- Priority: clr=1, ld=1, en=1 on the same edge with cnt=4 -> cnt=RST_VAL; ld alone with en=1 -> cnt=ld_val, no increment, co=0.
- Async reset: assert rst mid-cycle at cnt=3 -> cnt=0 and halted=0 before the next clk edge; tc=0. With MOD_COUNTER_SNAP_EN: snap at cnt=4 -> snap_val=4, unaffected by a later clr.
